md5_padder: RTL

Upstream front end of the MD5 datapath. Accepts a message as a byte stream with valid/ready handshake, packs the bytes into 512-bit blocks, and applies MD5 padding: a 0x80 byte, zero fill, and the 64-bit little-endian bit length. Each completed block is presented on a valid/ready output in the exact `message` layout that the 64-round MD5 pipeline consumes, with first/last flags for the digest-chaining logic.

---
 rtl/md5_pkg.sv | 23 ++
 rtl/md5_len_insert.sv | 38 +++
 rtl/md5_padder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 front end: FSM states, block geometry
// and the modes of the padding/length insertion helper.
package md5_pkg;

  localparam int         MD5_BLOCK_BYTES = 64;
  localparam int         MD5_LEN_OFFSET  = 56;
  localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_EMIT_DATA,
    ST_LENBLK,
    ST_EMIT_LAST
  } state_e;

  typedef enum logic [1:0] {
    INS_PAD,
    INS_LEN_80,
    INS_LEN_00
  } ins_mode_e;

endpackage

// File: rtl/md5_len_insert.sv
// Combinational padding helper: places the 0x80 marker, zero fill and the
// little-endian bit length into a 512-bit block according to the mode.
module md5_len_insert
  import md5_pkg::*;
(
  input  logic [511:0] blk_i,
  input  logic [5:0]   pos_i,
  input  logic [63:0]  bitlen_i,
  input  ins_mode_e    mode_i,
  output logic [511:0] blk_o
);

  always_comb begin
    blk_o = blk_i;
    unique case (mode_i)
      INS_PAD: begin
        for (int b = 0; b < MD5_BLOCK_BYTES; b++) begin
          if (b == int'(pos_i)) begin
            blk_o[8*b +: 8] = MD5_PAD_BYTE;
          end else if (b > int'(pos_i)) begin
            blk_o[8*b +: 8] = 8'h00;
          end
        end
        // The length only fits when the marker landed before the length field
        if (int'(pos_i) < MD5_LEN_OFFSET) begin
          blk_o[8*MD5_LEN_OFFSET +: 64] = bitlen_i;
        end
      end
      INS_LEN_80, INS_LEN_00: begin
        blk_o                         = '0;
        blk_o[8*MD5_LEN_OFFSET +: 64] = bitlen_i;
        blk_o[7:0]                    = (mode_i == INS_LEN_80) ? MD5_PAD_BYTE : 8'h00;
      end
      default: blk_o = blk_i;
    endcase
  end

endmodule

// File: rtl/md5_padder.sv
// MD5 front end: packs a byte stream into 512-bit blocks and applies MD5 padding.
// Optional sticky length-overflow flag under `define MD5_PADDER_OVERFLOW_EN.
module md5_padder
  import md5_pkg::*;
#(
  parameter int LEN_WIDTH = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] out_block,
  output logic         out_valid,
  output logic         out_first,
  output logic         out_last,
  input  logic         out_ready
`ifdef MD5_PADDER_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  state_e                 state_q, state_d;
  logic [511:0]           blk_q, blk_d;
  logic [5:0]             pos_q, pos_d;
  logic [LEN_WIDTH-1:0]   bitlen_q, bitlen_d;
  logic                   first_q, first_d;
  logic                   pad_pending_q, pad_pending_d;
  logic                   len_pending_q, len_pending_d;

  logic                   in_accept;
  logic                   out_fire;
  logic [LEN_WIDTH-1:0]   bitlen_inc;
  ins_mode_e              ins_mode;
  logic [511:0]           ins_blk;

  assign in_accept  = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign bitlen_inc = bitlen_q + LEN_WIDTH'(8);
  assign ins_mode   = (state_q == ST_PAD) ? INS_PAD
                    : (pad_pending_q ? INS_LEN_80 : INS_LEN_00);

  md5_len_insert u_len_insert (
    .blk_i    (blk_q),
    .pos_i    (pos_q),
    .bitlen_i (64'(bitlen_q)),
    .mode_i   (ins_mode),
    .blk_o    (ins_blk)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_accept && (in_last || pos_q == 6'd63)) begin
          state_d = (in_last && pos_q != 6'd63) ? ST_PAD : ST_EMIT_DATA;
        end
      end
      ST_PAD:       state_d = (pos_q >= 6'(MD5_LEN_OFFSET)) ? ST_EMIT_DATA : ST_EMIT_LAST;
      ST_EMIT_DATA: begin
        if (out_fire) begin
          state_d = (pad_pending_q || len_pending_q) ? ST_LENBLK : ST_FILL;
        end
      end
      ST_LENBLK:    state_d = ST_EMIT_LAST;
      ST_EMIT_LAST: if (out_fire) state_d = ST_FILL;
      default:      state_d = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_FILL);
    out_valid = (state_q == ST_EMIT_DATA) || (state_q == ST_EMIT_LAST);
    out_last  = (state_q == ST_EMIT_LAST);
  end

  assign out_block = blk_q;
  assign out_first = first_q;

  // Block buffer only moves in FILL/PAD/LENBLK, so it is frozen while presented
  always_comb begin
    blk_d         = blk_q;
    pos_d         = pos_q;
    bitlen_d      = bitlen_q;
    first_d       = first_q;
    pad_pending_d = pad_pending_q;
    len_pending_d = len_pending_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_accept) begin
          blk_d[{pos_q, 3'b000} +: 8] = in_data;
          pos_d                       = pos_q + 6'd1;
          bitlen_d                    = bitlen_inc;
          if (in_last && pos_q == 6'd63) pad_pending_d = 1'b1;
        end
      end
      ST_PAD: begin
        blk_d = ins_blk;
        if (pos_q >= 6'(MD5_LEN_OFFSET)) len_pending_d = 1'b1;
      end
      ST_EMIT_DATA: begin
        if (out_fire) begin
          first_d = 1'b0;
          pos_d   = 6'd0;
        end
      end
      ST_LENBLK: blk_d = ins_blk;
      ST_EMIT_LAST: begin
        if (out_fire) begin
          bitlen_d      = '0;
          pos_d         = 6'd0;
          pad_pending_d = 1'b0;
          len_pending_d = 1'b0;
          first_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_q         <= '0;
      pos_q         <= 6'd0;
      bitlen_q      <= '0;
      first_q       <= 1'b1;
      pad_pending_q <= 1'b0;
      len_pending_q <= 1'b0;
    end else begin
      blk_q         <= blk_d;
      pos_q         <= pos_d;
      bitlen_q      <= bitlen_d;
      first_q       <= first_d;
      pad_pending_q <= pad_pending_d;
      len_pending_q <= len_pending_d;
    end
  end

`ifdef MD5_PADDER_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (state_q == ST_FILL && in_accept && bitlen_inc == '0) begin
      overflow_d = 1'b1;
    end else if (state_q == ST_EMIT_LAST && out_fire) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule
